// File: rtl/evm_tally_n_pkg.sv
// Shared types and helpers for the evm_tally_n voting core.
package evm_pkg;

    localparam int MAX_CAND = 32;

    typedef logic [MAX_CAND-1:0] cand_vec_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VOTING  = 3'd1,
        TALLY   = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } evm_state_t;

    // Number of set bits; callers zero-extend their candidate vector into cand_vec_t.
    function automatic int unsigned popcount(input cand_vec_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_CAND; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // Exactly one bit set; an all-zero select is not one-hot.
    function automatic logic is_onehot(input cand_vec_t v);
        return popcount(v) == 32'd1;
    endfunction

endpackage

// File: rtl/evm_tally_n_if.sv
// Ballot-side and result-side signals of the voting core, bundled for port hookup.
interface evm_tally_n_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = $clog2(NUM_CAND + 1);
    localparam int TOT_W = CNT_W + $clog2(NUM_CAND);

    logic                      start;
    logic                      vote_valid;
    logic [NUM_CAND-1:0]       vote_sel;
    logic                      end_voting;
    logic                      voting_open;
    logic                      busy;
    logic                      vote_ack;
    logic                      vote_err;
    logic [NUM_CAND*CNT_W-1:0] count_flat;
    logic [TOT_W-1:0]          total_votes;
    logic [CNT_W-1:0]          reject_cnt;
    logic                      result_valid;
    logic [IDX_W-1:0]          winner;
    logic                      tie;
    logic [NUM_CAND-1:0]       tie_mask;

    modport master (
        output start, vote_valid, vote_sel, end_voting,
        input  voting_open, busy, vote_ack, vote_err, count_flat, total_votes,
               reject_cnt, result_valid, winner, tie, tie_mask
    );

    modport slave (
        input  start, vote_valid, vote_sel, end_voting,
        output voting_open, busy, vote_ack, vote_err, count_flat, total_votes,
               reject_cnt, result_valid, winner, tie, tie_mask
    );

endinterface

// File: rtl/evm_tally_n_max_scan.sv
// Sequential max/tie scanner: examines one candidate count per enabled cycle.
module evm_max_scan
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [CNT_W-1:0]    cnt_in,
    output logic [IDX_W-1:0]    idx,
    output logic [CNT_W-1:0]    max_val,
    output logic [NUM_CAND-1:0] mask
);

    logic [NUM_CAND-1:0] idx_oh;

    // One-hot form of the candidate currently being examined.
    always_comb begin
        idx_oh = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (idx == IDX_W'(i)) idx_oh[i] = 1'b1;
        end
    end

    // Running maximum and the set of candidates holding it; zero counts never join.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            max_val <= '0;
            mask    <= '0;
        end else if (clr) begin
            idx     <= '0;
            max_val <= '0;
            mask    <= '0;
        end else if (en) begin
            if (cnt_in > max_val) begin
                max_val <= cnt_in;
                mask    <= idx_oh;
            end else if (cnt_in == max_val && cnt_in != '0) begin
                mask    <= mask | idx_oh;
            end
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/evm_tally_n.sv
// N-candidate voting core: election control, saturating vote counters, winner/tie publication.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | after reset, nothing open
//   VOTING  | ballots accepted, one vote per vote_valid cycle
//   TALLY   | scanner walks one candidate per cycle for NUM_CAND cycles
//   RESOLVE | scan complete, winner/tie decided on the exit edge
//   DONE    | results and counts held until the next start
module evm_tally_n
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    evm_tally_n_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_CAND + 1);
    localparam int TOT_W = CNT_W + $clog2(NUM_CAND);

    evm_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND];
    logic [TOT_W-1:0]    total_q;
    logic [CNT_W-1:0]    reject_q;
    logic                ack_q;
    logic                err_q;
    logic                result_valid_q;
    logic [IDX_W-1:0]    winner_q;
    logic                tie_q;
    logic [NUM_CAND-1:0] tie_mask_q;

    logic [CNT_W-1:0]          sel_cnt;
    logic [CNT_W-1:0]          scan_cnt;
    logic [IDX_W-1:0]          scan_idx;
    logic [CNT_W-1:0]          scan_max;
    logic [NUM_CAND-1:0]       scan_mask;
    logic [IDX_W-1:0]          win_idx;
    logic [NUM_CAND*CNT_W-1:0] flat;
    logic                      vote_ok;
    logic                      scan_clr;
    logic                      scan_en;

    // Count of the selected candidate (meaningful only when the select is one-hot).
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (bus.vote_sel[i]) sel_cnt = sel_cnt | cnt_q[i];
        end
    end

    assign vote_ok = is_onehot(cand_vec_t'(bus.vote_sel)) && (sel_cnt != {CNT_W{1'b1}});

    // Feed the scanner the count at its current index, and pack counts for readout.
    always_comb begin
        scan_cnt = '0;
        flat     = '0;
        win_idx  = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (scan_idx == IDX_W'(i)) scan_cnt = cnt_q[i];
            if (scan_mask[i])          win_idx  = IDX_W'(i + 1);
            flat[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // The scanner is cleared on the same edge that closes voting, so a vote
    // landing on that edge is already in cnt_q when the scan begins.
    assign scan_clr = (state_q == VOTING) && bus.end_voting;
    assign scan_en  = (state_q == TALLY);

    evm_max_scan #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .IDX_W    (IDX_W)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (scan_clr),
        .en      (scan_en),
        .cnt_in  (scan_cnt),
        .idx     (scan_idx),
        .max_val (scan_max),
        .mask    (scan_mask)
    );

    // Election FSM with counters, vote pulses and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            total_q        <= '0;
            reject_q       <= '0;
            ack_q          <= 1'b0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
            winner_q       <= '0;
            tie_q          <= 1'b0;
            tie_mask_q     <= '0;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        total_q        <= '0;
                        reject_q       <= '0;
                        result_valid_q <= 1'b0;
                        winner_q       <= '0;
                        tie_q          <= 1'b0;
                        tie_mask_q     <= '0;
                        for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
                        state_q        <= VOTING;
                    end
                end
                VOTING: begin
                    if (bus.vote_valid) begin
                        if (vote_ok) begin
                            for (int i = 0; i < NUM_CAND; i++) begin
                                if (bus.vote_sel[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                            total_q <= total_q + 1'b1;
                            ack_q   <= 1'b1;
                        end else begin
                            if (reject_q != {CNT_W{1'b1}}) reject_q <= reject_q + 1'b1;
                            err_q <= 1'b1;
                        end
                    end
                    if (bus.end_voting) state_q <= TALLY;
                end
                TALLY: begin
                    if (scan_idx == IDX_W'(NUM_CAND - 1)) state_q <= RESOLVE;
                end
                RESOLVE: begin
                    if (scan_max == '0) begin
                        winner_q <= '0;
                        tie_q    <= 1'b0;
                    end else if (popcount(cand_vec_t'(scan_mask)) == 32'd1) begin
                        winner_q <= win_idx;
                        tie_q    <= 1'b0;
                    end else begin
                        winner_q <= '0;
                        tie_q    <= 1'b1;
                    end
                    tie_mask_q     <= scan_mask;
                    result_valid_q <= 1'b1;
                    state_q        <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.voting_open  = (state_q == VOTING);
    assign bus.busy         = (state_q == TALLY) || (state_q == RESOLVE);
    assign bus.vote_ack     = ack_q;
    assign bus.vote_err     = err_q;
    assign bus.count_flat   = flat;
    assign bus.total_votes  = total_q;
    assign bus.reject_cnt   = reject_q;
    assign bus.result_valid = result_valid_q;
    assign bus.winner       = winner_q;
    assign bus.tie          = tie_q;
    assign bus.tie_mask     = tie_mask_q;

endmodule
